// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and funct3 encodings for the MEM-stage load/store unit.
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2
  } lsu_state_t;

  typedef enum logic {
    EXC_MISALIGNED = 1'b0,
    EXC_ILLEGAL    = 1'b1
  } lsu_exc_t;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] SB  = 3'd0;
  localparam logic [2:0] SH  = 3'd1;
  localparam logic [2:0] SW  = 3'd2;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Extracts the addressed byte/half/word from a read word and sign- or zero-extends it.
module lsu_load_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] byte_v;
  logic [31:0] half_v;

  always_comb begin
    byte_v = rdata >> {offset, 3'b000};
    half_v = rdata >> {offset[1], 4'b0000};
    case (funct3)
      LB:      result = {{24{byte_v[7]}}, byte_v[7:0]};
      LH:      result = {{16{half_v[15]}}, half_v[15:0]};
      LBU:     result = {24'd0, byte_v[7:0]};
      LHU:     result = {16'd0, half_v[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: registers one load/store onto a req/gnt/rvalid data port and
// returns aligned, extended load data to WB; faulting ops raise a one-cycle exception.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [4:0]      ex_rd,
  input  logic            flush,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            exc_valid,
  output logic            exc_cause,
  output logic [XLEN-1:0] exc_addr,
  output logic            stall
);

  lsu_state_t      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic [4:0]      ld_rd_q, ld_rd_d;
  logic            wb_valid_q, wb_valid_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            exc_valid_q, exc_valid_d;
  lsu_exc_t        exc_cause_q, exc_cause_d;
  logic [XLEN-1:0] exc_addr_q, exc_addr_d;

  logic            accept;
  logic            illegal;
  logic            misaligned;
  logic [3:0]      be_c;
  logic [XLEN-1:0] wdata_c;
  logic [XLEN-1:0] ld_result;

  lsu_load_align u_load_align (
    .rdata  (dmem_rdata),
    .offset (ld_off_q),
    .funct3 (ld_f3_q),
    .result (ld_result)
  );

  // Decode of the op presented by EX: legality, alignment and byte lanes.
  always_comb begin
    accept     = ex_valid && (ex_mem_read || ex_mem_write) && !flush && (state_q == IDLE);
    illegal    = ex_mem_read ? (ex_funct3 == 3'd3 || ex_funct3 == 3'd6 || ex_funct3 == 3'd7)
                             : (ex_funct3 >= 3'd3);
    misaligned = ((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
                 ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00));
    case (ex_funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << ex_addr[1:0];
        wdata_c = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {ex_addr[1], 1'b0};
        wdata_c = {2{ex_wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = ex_wdata;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    ld_f3_d     = ld_f3_q;
    ld_off_d    = ld_off_q;
    ld_rd_d     = ld_rd_q;
    wb_valid_d  = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_addr_d  = exc_addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (illegal || misaligned) begin
            // Faulting op is consumed here and never reaches the bus.
            exc_valid_d = 1'b1;
            exc_cause_d = illegal ? EXC_ILLEGAL : EXC_MISALIGNED;
            exc_addr_d  = ex_addr;
          end else begin
            state_d  = REQ;
            req_d    = 1'b1;
            we_d     = ex_mem_write;
            addr_d   = {ex_addr[XLEN-1:2], 2'b00};
            be_d     = be_c;
            wdata_d  = wdata_c;
            ld_f3_d  = ex_funct3;
            ld_off_d = ex_addr[1:0];
            ld_rd_d  = ex_rd;
          end
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          state_d = we_q ? IDLE : WAIT_R;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          be_d    = 4'b0000;
          wdata_d = '0;
        end
      end
      WAIT_R: begin
        if (dmem_rvalid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_rd_d    = ld_rd_q;
          wb_data_d  = ld_result;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= '0;
      ld_f3_q     <= 3'd0;
      ld_off_q    <= 2'd0;
      ld_rd_q     <= 5'd0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= EXC_MISALIGNED;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      ld_f3_q     <= ld_f3_d;
      ld_off_q    <= ld_off_d;
      ld_rd_q     <= ld_rd_d;
      wb_valid_q  <= wb_valid_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign ex_ready   = (state_q == IDLE);
  assign stall      = (state_q != IDLE);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign exc_valid  = exc_valid_q;
  assign exc_cause  = exc_cause_q;
  assign exc_addr   = exc_addr_q;

endmodule
